// File: rtl/l7_loop_pkg.sv
// Shared layer-7 loop dimensions and controller state encoding.
// The J counter and the address generator import the same definitions.
package l7_loop_pkg;

   localparam int unsigned L_MAX = 15;
   localparam int unsigned L_W   = 4;
   localparam int unsigned U_MAX = 4;
   localparam int unsigned U_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lu_loop_ctrl_l7_wrap_count.sv
// Wrapping index counter: counts 0..MAX on en, synchronous clear, wrap strobe at MAX.
module wrap_count #(
   parameter int unsigned MAX = 15,
   parameter int unsigned W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         wrap
);

   localparam logic [W-1:0] C_MAX = W'(MAX);

   if (MAX >= (64'd1 << W)) begin : g_bad_width
      $error("wrap_count: MAX does not fit in W bits");
   end

   logic [W-1:0] r_q;
   logic         w_at_max;

   assign w_at_max = (r_q == C_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= w_at_max ? '0 : r_q + 1'b1;
      end
   end

   assign q    = r_q;
   assign wrap = en && w_at_max;

endmodule

// File: rtl/lu_loop_ctrl_l7.sv
// Layer-7 L/u loop controller: steps L every active cycle, u on each L wrap,
// and closes the frame when the J counter reports its last step on an L wrap.
module lu_loop_ctrl_l7
   import l7_loop_pkg::*;
#(
   parameter int unsigned L_MAX = l7_loop_pkg::L_MAX,
   parameter int unsigned L_W   = l7_loop_pkg::L_W,
   parameter int unsigned U_MAX = l7_loop_pkg::U_MAX,
   parameter int unsigned U_W   = l7_loop_pkg::U_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           stall,
   input  logic           j_zero,
   input  logic           temp_zero,
   output logic [L_W-1:0] l,
   output logic [U_W-1:0] u,
   output logic           L_zero,
   output logic           u_zero,
   output logic           busy,
   output logic           done
);

   state_t r_state;
   logic   r_busy;
   logic   r_done;
   logic   w_adv;
   logic   w_l_zero;
   logic   w_u_zero;

   // temp_zero both blocks the step and clears the counters on the same edge
   assign w_adv = (r_state == RUN) && !stall && !temp_zero;

   wrap_count #(
      .MAX (L_MAX),
      .W   (L_W)
   ) u_l_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (w_adv),
      .clr  (temp_zero),
      .q    (l),
      .wrap (w_l_zero)
   );

   wrap_count #(
      .MAX (U_MAX),
      .W   (U_W)
   ) u_u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (w_l_zero),
      .clr  (temp_zero),
      .q    (u),
      .wrap (w_u_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start && !temp_zero) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               if (temp_zero) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (j_zero && w_l_zero) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // j_zero is only meaningful on an L wrap unless it is a flush
   a_jzero_on_lwrap: assert property (@(posedge clk) disable iff (rst)
      (r_state == RUN && j_zero && !temp_zero) |-> w_l_zero);

   assign L_zero = w_l_zero;
   assign u_zero = w_u_zero;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_lu_loop_ctrl_l7.sv
// Directed bench for lu_loop_ctrl_l7 (L_MAX=3) closed around a small J counter model.
module tb_lu_loop_ctrl_l7;

   localparam int unsigned L_MAX = 3;
   localparam int unsigned L_W   = 4;
   localparam int unsigned U_MAX = 4;
   localparam int unsigned U_W   = 3;
   localparam int          FRAME = 60;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           stall = 1'b0;
   logic           temp_zero = 1'b0;
   logic           j_zero;
   logic [L_W-1:0] l;
   logic [U_W-1:0] u;
   logic           L_zero;
   logic           u_zero;
   logic           busy;
   logic           done;
   logic [1:0]     j;

   int n_checks = 0;
   int n_errors = 0;

   lu_loop_ctrl_l7 #(
      .L_MAX (L_MAX),
      .L_W   (L_W),
      .U_MAX (U_MAX),
      .U_W   (U_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stall     (stall),
      .j_zero    (j_zero),
      .temp_zero (temp_zero),
      .l         (l),
      .u         (u),
      .L_zero    (L_zero),
      .u_zero    (u_zero),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // J counter: steps on u wrap, closes at j==2, flushes on temp_zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            j <= 2'd0;
      else if (temp_zero) j <= 2'd0;
      else if (u_zero)    j <= (j == 2'd2) ? 2'd0 : j + 2'd1;
   end
   assign j_zero = temp_zero || (u_zero && (j == 2'd2));

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Walks one frame; p counts advancing cycles, expected indices derive from p.
   task automatic run_frame(input int stall_p, input int stall_n, input int abort_p,
                            input int rst_p, input bit hold_start);
      int p = 0;
      int stalls = 0;
      int cyc = 0;
      bit fin = 0;
      bit st;
      bit tz;
      @(negedge clk);
      start = 1'b1; stall = 1'b0; temp_zero = 1'b0;
      #1;
      check_eq("idle_busy", busy, 0);
      while (!fin && cyc < 200) begin
         @(negedge clk);
         if (!hold_start) start = 1'b0;
         st = (p == stall_p) && (stalls < stall_n);
         tz = (p == abort_p);
         stall = st; temp_zero = tz;
         #1;
         cyc++;
         check_eq("run_busy", busy, 1);
         check_eq("run_done", done, 0);
         check_eq("l", l, p % 4);
         check_eq("u", u, (p / 4) % 5);
         check_eq("j", j, p / 20);
         check_eq("L_zero", L_zero, (!st && !tz && (p % 4 == 3)) ? 1 : 0);
         check_eq("u_zero", u_zero, (!st && !tz && (p % 20 == 19)) ? 1 : 0);
         if (p == rst_p) begin
            #2 rst = 1'b1;
            #1;
            check_eq("arst_busy", busy, 0);
            check_eq("arst_l", l, 0);
            check_eq("arst_u", u, 0);
            check_eq("arst_Lz", L_zero, 0);
            check_eq("arst_j", j, 0);
            @(negedge clk);
            rst = 1'b0; start = 1'b0; stall = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk); #1;
               check_eq("post_rst_busy", busy, 0);
               check_eq("post_rst_l", l, 0);
               check_eq("post_rst_done", done, 0);
            end
            fin = 1;
         end else if (tz) begin
            @(negedge clk);
            temp_zero = 1'b0; start = 1'b0;
            #1;
            check_eq("abort_busy", busy, 0);
            check_eq("abort_done", done, 0);
            check_eq("abort_l", l, 0);
            check_eq("abort_u", u, 0);
            check_eq("abort_j", j, 0);
            fin = 1;
         end else begin
            if (st) stalls++;
            else    p++;
            if (p == FRAME) begin
               @(negedge clk);
               stall = 1'b0;
               #1;
               check_eq("done_pulse", done, 1);
               check_eq("done_busy", busy, 0);
               check_eq("frame_len", cyc, FRAME + stall_n);
               check_eq("done_l", l, 0);
               @(negedge clk); #1;
               check_eq("after_done", done, 0);
               check_eq("after_busy", busy, 0);
               fin = 1;
            end
         end
      end
      if (!fin) check_eq("timeout", 0, 1);
      stall = 1'b0; temp_zero = 1'b0;
   endtask

   initial begin
      #2;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_l", l, 0);
      check_eq("rst_u", u, 0);
      check_eq("rst_Lz", L_zero, 0);
      check_eq("rst_uz", u_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      // start alongside temp_zero is refused
      @(negedge clk);
      start = 1'b1; temp_zero = 1'b1;
      @(negedge clk);
      start = 1'b0; temp_zero = 1'b0;
      #1;
      check_eq("start_tz_busy", busy, 0);

      run_frame(-1, 0, -1, -1, 1'b0);   // plain frame
      run_frame(6, 5, -1, -1, 1'b0);    // stall at l=2,u=1
      run_frame(-1, 0, 29, -1, 1'b0);   // abort at cycle 30
      run_frame(-1, 0, -1, -1, 1'b0);   // full frame after abort
      run_frame(-1, 0, 59, -1, 1'b0);   // abort coincides with j_zero/L_zero

      // start held: one frame, restart only from IDLE after DONE
      run_frame(-1, 0, -1, -1, 1'b1);
      @(negedge clk); #1;
      check_eq("restart_busy", busy, 1);
      check_eq("restart_l", l, 0);
      start = 1'b0; temp_zero = 1'b1;
      @(negedge clk);
      temp_zero = 1'b0;
      #1;
      check_eq("restart_abort_busy", busy, 0);

      run_frame(-1, 0, -1, 44, 1'b0);   // async reset at cycle 45

      // stall in IDLE has no effect on a following start
      @(negedge clk);
      stall = 1'b1;
      @(negedge clk); #1;
      check_eq("idle_stall_busy", busy, 0);
      stall = 1'b0;
      run_frame(-1, 0, -1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
